// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_round_robin_arbiter_if.sv
// Request/grant/data bundle between requesters and the arbiter.
interface mux_round_robin_arbiter_if;
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data_in;
    logic [N_REQ-1:0] grant;
    logic             grant_valid;
    logic [SEL_W-1:0] sel;
    logic             data_out;
    logic             data_valid;

    modport master (
        output req, data_in,
        input  grant, grant_valid, sel, data_out, data_valid
    );

    modport slave (
        input  req, data_in,
        output grant, grant_valid, sel, data_out, data_valid
    );

endinterface

// File: rtl/mux_round_robin_arbiter_rr_picker.sv
// Combinational round-robin search: first set, non-excluded request bit
// found scanning upward from ptr with wrap-around.
module rr_picker
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        masked = req & ~exclude;
        found  = 1'b0;
        idx    = '0;
        cand   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (masked[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter driving an 8:1 mux select, with a per-owner hold limit
// and a one-cycle registered data path from the selected input.
module mux_round_robin_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    mux_round_robin_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0  = N_REQ'(1);

    arb_state_t        state_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  owner_q;
    logic [HOLD_W-1:0] hold_q;
    logic [N_REQ-1:0]  grant_q;
    logic              grant_valid_q;
    logic [SEL_W-1:0]  sel_q;
    logic              data_out_q;
    logic              data_valid_q;

    logic              owner_req;
    logic [SEL_W-1:0]  pick_ptr;
    logic [N_REQ-1:0]  pick_excl;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;

    assign owner_req = bus.req[owner_q];

    // When busy, the search always starts just past the owner; a releasing
    // owner is masked out so it can never be handed the grant back.
    always_comb begin
        pick_ptr  = ptr_q;
        pick_excl = '0;
        if (state_q == BUSY) begin
            pick_ptr = owner_q + SEL_W'(1);
            if (!owner_req) begin
                pick_excl = ONE_HOT0 << owner_q;
            end
        end
    end

    rr_picker u_picker (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Arbitration state, hold counting and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            hold_q        <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            sel_q         <= '0;
            data_out_q    <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            data_out_q   <= bus.data_in[sel_q];
            data_valid_q <= grant_valid_q;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q       <= BUSY;
                        owner_q       <= pick_idx;
                        hold_q        <= '0;
                        grant_q       <= ONE_HOT0 << pick_idx;
                        grant_valid_q <= 1'b1;
                        sel_q         <= pick_idx;
                    end else begin
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (owner_req && (hold_q < HOLD_LAST)) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end else begin
                        ptr_q <= pick_ptr;
                        if (pick_found) begin
                            owner_q       <= pick_idx;
                            hold_q        <= '0;
                            grant_q       <= ONE_HOT0 << pick_idx;
                            grant_valid_q <= 1'b1;
                            sel_q         <= pick_idx;
                        end else begin
                            state_q       <= IDLE;
                            grant_q       <= '0;
                            grant_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.sel         = sel_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;

endmodule

// File: doc/mux_round_robin_arbiter.md
MUX_ROUND_ROBIN_ARBITER -- requirements
Module: mux_round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 4, giving the maximum consecutive grant cycles per owner (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 8, request bit per requester 0..7.
REQ-005 The block SHALL have port data_in, input, 8, the eight mux input lines; bit i belongs to requester i.
REQ-006 The block SHALL have port grant, output, 8, one-hot registered grant; all-zero when no owner.
REQ-007 The block SHALL have port grant_valid, output, 1, high when grant is non-zero.
REQ-008 The block SHALL have port sel, output, 3, binary index of the current owner, for the 8:1 mux selector.
REQ-009 The block SHALL have port data_out, output, 1, registered copy of data_in[sel].
REQ-010 The block SHALL have port data_valid, output, 1, high when data_out carries an owner's sample.

Function
REQ-011 The state machine SHALL have states IDLE (no owner) and BUSY (one owner).
REQ-012 Arbitration SHALL pick the first set req bit scanning upward from priority pointer ptr, with wrap 7->0.
REQ-013 In IDLE, if any req is set at edge N, the block SHALL enter BUSY with grant/sel/grant_valid valid after edge N (one-cycle latency) and hold_cnt=0.
REQ-014 In IDLE with req==0, the block SHALL remain IDLE with grant=0 and grant_valid=0.
REQ-015 In BUSY, while req[owner]=1 and hold_cnt<HOLD_MAX-1, the block SHALL hold grant and increment hold_cnt each cycle.
REQ-016 On release (req[owner]=0) the block SHALL set ptr=owner+1 mod 8 and re-arbitrate at the same edge, excluding the releasing owner.
REQ-017 On expiry (hold_cnt==HOLD_MAX-1 with req[owner]=1) the block SHALL set ptr=owner+1 mod 8 and re-arbitrate at the same edge.
REQ-018 On expiry, if the owner is the only requester, the block SHALL re-grant the same owner and reset hold_cnt to 0.
REQ-019 When re-arbitration finds a requester, the new grant SHALL appear at that edge with no idle bubble.
REQ-020 When re-arbitration finds no requester, the block SHALL enter IDLE and clear grant and grant_valid.
REQ-021 With HOLD_MAX=1, every grant SHALL last exactly one cycle.
REQ-022 sel SHALL track the owner while BUSY and SHALL retain its last value in IDLE.
REQ-023 On every edge, data_out SHALL take data_in[sel] and data_valid SHALL take grant_valid (one-cycle pipeline).
REQ-024 Request changes in non-owners SHALL NOT affect the current grant.

Reset
REQ-025 While reset=1 at an edge, the block SHALL load state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_valid=0, sel=0, data_out=0 and data_valid=0.
REQ-026 Reset asserted mid-grant SHALL drop grant at that edge, and no req SHALL be honoured until the first edge with reset=0.

Structure
REQ-027 Package mux_arb_pkg SHALL hold N_REQ=8, SEL_W=3 and the state enum {IDLE, BUSY}.
REQ-028 A sub-module rr_picker SHALL be purely combinational and SHALL map (req, ptr, exclude mask) to a found flag and a 3-bit index.
REQ-029 The block SHALL contain exactly one always_ff holding state, ptr, owner, hold_cnt and the output registers.

Verification
REQ-030 The bench SHALL check that with req=8'h01 held and HOLD_MAX=4, grant=8'h01 and sel=0 one cycle later, the grant is re-issued every 4 cycles, and grant_valid stays continuously 1.
REQ-031 The bench SHALL check that with req=8'hFF held, grants rotate 0,1,...,7,0 with 4 cycles each and no bubble.
REQ-032 The bench SHALL check that with ptr=6 and req=8'h41, the next grant is 8'h40 and, after requester 6 releases, the grant is 8'h01 (wrap).
REQ-033 The bench SHALL check that when requester 3 drops req after 2 cycles with req=8'h08 only, the block enters IDLE next edge with grant=0 and sel=3 retained.
REQ-034 The bench SHALL check that data_in=8'b0010_0000 with owner 5 gives data_out=1 and data_valid=1 one cycle after grant.
REQ-035 The bench SHALL check that reset asserted mid-grant with req=8'hFF gives all outputs 0 next edge, and that the first grant after reset deassertion is 8'h01.
